// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming popcount block.
// Widths derive from the instance parameters via the functions below.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  function automatic int cnt_w(input int chunk_width);
    return $clog2(chunk_width + 1);
  endfunction

  function automatic int acc_w(input int data_width, input int max_words);
    return $clog2(data_width * max_words + 1);
  endfunction

  function automatic int idx_w(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/popcount_stream_chunk.sv
// Combinational set-bit count of one chunk slice.
// Instantiated once per chunk in the register stage.
module chunk_popcount #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// Streaming packet popcount: chunk counts, accumulate, backpressured result.
// Two pipeline stages, both stalled whenever the result port is blocked.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4,
  parameter int MAX_WORDS   = 16,
  localparam int ACC_W = acc_w(DATA_WIDTH, MAX_WORDS),
  localparam int IDX_W = idx_w(MAX_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_last,
  input  logic                  count_zeros,
  output logic                  din_ready,
  output logic [ACC_W-1:0]      dout,
  output logic [IDX_W-1:0]      dout_words,
  output logic                  dout_ovf,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = cnt_w(CHUNK_WIDTH);

  logic [DATA_WIDTH-1:0] word;
  logic [CNT_W-1:0]      chunk_cnt [NUM_CHUNKS];
  logic [CNT_W-1:0]      a_cnt     [NUM_CHUNKS];
  logic                  a_valid;
  logic                  a_last;
  logic                  accept;
  logic                  b_fire;

  logic [ACC_W-1:0] acc, acc_nxt, word_cnt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             ovf, ovf_nxt, full;

  state_t state, state_nxt;
  logic   open_nxt;

  assign din_ready = !dout_valid || dout_ready;
  assign accept    = din_valid && din_ready;
  assign b_fire    = din_ready && a_valid;
  assign word      = count_zeros ? ~din : din;

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
    chunk_popcount #(
      .W  (CHUNK_WIDTH),
      .CW (CNT_W)
    ) u_cnt (
      .bits  (word[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .count (chunk_cnt[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      for (int i = 0; i < NUM_CHUNKS; i++) a_cnt[i] <= '0;
    end else if (din_ready) begin
      a_valid <= accept;
      if (accept) begin
        a_cnt  <= chunk_cnt;
        a_last <= din_last;
      end
    end
  end

  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      word_cnt = word_cnt + ACC_W'(a_cnt[i]);
    end
  end

  // Words beyond the limit are dropped from the sum but flagged.
  assign full    = idx == IDX_W'(MAX_WORDS);
  assign acc_nxt = full ? acc : acc + word_cnt;
  assign idx_nxt = full ? idx : idx + IDX_W'(1);
  assign ovf_nxt = ovf || full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      idx        <= '0;
      ovf        <= 1'b0;
      dout       <= '0;
      dout_words <= '0;
      dout_ovf   <= 1'b0;
      dout_valid <= 1'b0;
    end else if (din_ready) begin
      dout_valid <= b_fire && a_last;
      if (b_fire && a_last) begin
        dout       <= acc_nxt;
        dout_words <= idx_nxt;
        dout_ovf   <= ovf_nxt;
        acc        <= '0;
        idx        <= '0;
        ovf        <= 1'b0;
      end else if (b_fire) begin
        acc <= acc_nxt;
        idx <= idx_nxt;
        ovf <= ovf_nxt;
      end
    end
  end

  assign open_nxt = (accept && !din_last) ||
                    (!(b_fire && a_last) && (idx != '0 || a_valid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && !din_last) state_nxt = ACCUM;
      ACCUM:   if (b_fire && a_last && !(accept && !din_last))
                 state_nxt = IDLE;
      HOLD:    if (dout_ready) state_nxt = open_nxt ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (dout_valid && !dout_ready) state_nxt = HOLD;
  end

endmodule

// File: tb/tb_popcount_stream.sv
// Self-checking bench for popcount_stream (16-bit words, 4-bit chunks, 4 words).
// Results are checked against a scoreboard of expected packet totals.
module tb_popcount_stream;

  localparam int DW = 16;
  localparam int MW = 4;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        din_last;
  logic        count_zeros;
  logic        din_ready;
  logic [6:0]  dout;
  logic [2:0]  dout_words;
  logic        dout_ovf;
  logic        dout_valid;
  logic        dout_ready;

  popcount_stream #(
    .DATA_WIDTH  (DW),
    .CHUNK_WIDTH (4),
    .MAX_WORDS   (MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .din_last    (din_last),
    .count_zeros (count_zeros),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_words  (dout_words),
    .dout_ovf    (dout_ovf),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d;
    int w;
    int o;
  } res_t;

  typedef struct {
    logic [15:0] din;
    logic        zeros;
    int          exp;
  } vec_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_done;

  int m_sum, m_words, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Every consumed result is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      check("result_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        res_t r;
        r = exp_q.pop_front();
        check("dout", int'(dout), r.d);
        check("dout_words", int'(dout_words), r.w);
        check("dout_ovf", int'(dout_ovf), r.o);
      end
    end
  end

  function automatic void expect_res(input int d, input int w, input int o);
    res_t r;
    r.d = d;
    r.w = w;
    r.o = o;
    exp_q.push_back(r);
  endfunction

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive(input logic [15:0] d, input logic z, input logic l);
    bit ok;
    int n;
    din         = d;
    count_zeros = z;
    din_last    = l;
    din_valid   = 1'b1;
    ok          = 1'b0;
    n           = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = din_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) check("accept_timeout", n, 0);
    #1;
    din_valid = 1'b0;
  endtask

  // Reference: words past the limit add nothing but flag overflow.
  task automatic model_word(input logic [15:0] d, input logic z,
                            input logic l);
    int c;
    c = $countones(z ? ~d : d);
    if (m_words == MW) m_ovf = 1;
    else begin
      m_sum += c;
      m_words++;
    end
    if (l) begin
      expect_res(m_sum, m_words, m_ovf);
      m_sum   = 0;
      m_words = 0;
      m_ovf   = 0;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'h0000, 1'b0, 0};
    vecs[1] = '{16'hFFFF, 1'b1, 0};
    vecs[2] = '{16'h0000, 1'b1, 16};
    vecs[3] = '{16'h8001, 1'b0, 2};
    vecs[4] = '{16'hA5A5, 1'b0, 8};
    vecs[5] = '{16'h1234, 1'b0, 5};
    vecs[6] = '{16'hF0F0, 1'b1, 8};
    vecs[7] = '{16'h7FFF, 1'b0, 15};

    reset       = 1'b1;
    din         = '0;
    din_valid   = 1'b0;
    din_last    = 1'b0;
    count_zeros = 1'b0;
    dout_ready  = 1'b1;
    rand_done   = 1'b0;
    m_sum       = 0;
    m_words     = 0;
    m_ovf       = 0;

    #12;
    check("rst_dout", int'(dout), 0);
    check("rst_words", int'(dout_words), 0);
    check("rst_ovf", int'(dout_ovf), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_ready", int'(din_ready), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    settle(1);

    // Single word: valid exactly two edges after accept, for one cycle.
    expect_res(16, 1, 0);
    drive(16'hFFFF, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_valid_e1", int'(dout_valid), 0);
    @(negedge clk);
    check("lat_valid_e2", int'(dout_valid), 1);
    check("lat_dout", int'(dout), 16);
    @(negedge clk);
    check("lat_valid_e3", int'(dout_valid), 0);
    check("lat_dout_kept", int'(dout), 16);
    settle(1);

    for (int i = 0; i < 8; i++) begin
      expect_res(vecs[i].exp, 1, 0);
      drive(vecs[i].din, vecs[i].zeros, 1'b1);
    end
    settle(3);

    // Multi-word packet followed immediately by a one-word packet.
    expect_res(13, 3, 0);
    expect_res(2, 1, 0);
    drive(16'h000F, 1'b0, 1'b0);
    drive(16'h00FF, 1'b0, 1'b0);
    drive(16'h0001, 1'b0, 1'b1);
    drive(16'h0003, 1'b0, 1'b1);
    settle(4);

    // Backpressure: result held, next word stalls until consume.
    expect_res(16, 1, 0);
    expect_res(2, 1, 0);
    dout_ready = 1'b0;
    drive(16'hFFFF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    din       = 16'h0101;
    din_last  = 1'b1;
    din_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_din_ready", int'(din_ready), 0);
      check("bp_valid", int'(dout_valid), 1);
      check("bp_dout", int'(dout), 16);
    end
    @(posedge clk);
    #1 dout_ready = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    settle(4);

    // Overflow then a fresh packet with flags cleared.
    expect_res(64, 4, 1);
    expect_res(1, 1, 0);
    for (int i = 0; i < 5; i++) drive(16'hFFFF, 1'b0, i == 4);
    drive(16'h0001, 1'b0, 1'b1);
    settle(4);

    // Zero counting, including a mixed-mode packet.
    expect_res(14, 1, 0);
    expect_res(16, 2, 0);
    drive(16'h0003, 1'b1, 1'b1);
    drive(16'h00FF, 1'b0, 1'b0);
    drive(16'h00FF, 1'b1, 1'b1);
    settle(4);

    // Asynchronous reset mid-packet discards the partial packet.
    drive(16'hFFFF, 1'b0, 1'b0);
    drive(16'hFFFF, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_words", int'(dout_words), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_ready", int'(din_ready), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    expect_res(3, 1, 0);
    drive(16'h0007, 1'b0, 1'b1);
    settle(4);

    // Random traffic with random backpressure against the model.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 dout_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      logic [15:0] d;
      logic        z;
      logic        l;
      d = 16'($urandom);
      z = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 4) == 0) || (i == 299);
      model_word(d, z, l);
      drive(d, z, l);
      if ($urandom_range(0, 3) == 0) settle($urandom_range(1, 3));
    end
    rand_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 dout_ready = 1'b1;
    settle(10);
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
